uart_rx_ctrl: RTL and testbench

Receive-side sequencer for the UART receiver. It detects the start bit on the serial line using oversampled ticks, then drives the SIPO shift enables bit by bit. It captures the parity bit and issues the one-cycle `parity_load` strobe to the parity checker. It validates the stop bit and presents a completed frame to the host through a valid/ack handshake, with framing and overrun status.

---
 rtl/uart_rx_ctrl_if.sv | 27 ++
 rtl/uart_rx_ctrl.sv | 169 ++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_ctrl_if.sv
// Handshake/status bundle between the UART receive sequencer and its neighbours.
// master = sequencer side (drives SIPO/parity/host status), slave = environment side.
interface uart_rx_ctrl_if;
  logic sample_tick;
  logic rx;
  logic rx_ack;
  logic sipo_shift;
  logic sipo_bit;
  logic parity_bit;
  logic parity_load;
  logic rx_valid;
  logic framing_error;
  logic overrun;
  logic busy;

  modport master (
    input  sample_tick, rx, rx_ack,
    output sipo_shift, sipo_bit, parity_bit, parity_load,
    output rx_valid, framing_error, overrun, busy
  );

  modport slave (
    output sample_tick, rx, rx_ack,
    input  sipo_shift, sipo_bit, parity_bit, parity_load,
    input  rx_valid, framing_error, overrun, busy
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start detect, mid-bit SIPO shifts, parity capture (UART_RX_PARITY_EN), stop check.
// Latency: 2-clk rx synchroniser, all outputs registered; rx_valid rises 1 clk after the stop sample.
// Backpressure: none on the line; a completed frame with rx_valid still unacked sets sticky overrun.
module uart_rx_ctrl #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_rx_ctrl_if.master bus
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS) + 1;
  localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state, state_nxt;
  logic          rx_meta, rx_s;
  logic [TW-1:0] tick_cnt, tick_cnt_nxt;
  logic [BW-1:0] bit_cnt, bit_cnt_nxt;
  logic          sipo_shift_q, sipo_shift_nxt;
  logic          sipo_bit_q, sipo_bit_nxt;
  logic          rx_valid_q, rx_valid_nxt;
  logic          ferr_q, ferr_nxt;
  logic          ovr_q, ovr_nxt;
  logic          busy_q, busy_nxt;
  logic          tick_mid, tick_end;
`ifdef UART_RX_PARITY_EN
  logic          parity_bit_q, parity_bit_nxt;
  logic          parity_pend_q, parity_pend_nxt;
  logic          parity_load_q;
`endif

  assign tick_mid = bus.sample_tick && (tick_cnt == TICK_MID);
  assign tick_end = bus.sample_tick && (tick_cnt == TICK_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
    end
  end

  always_comb begin
    state_nxt      = state;
    tick_cnt_nxt   = bus.sample_tick ? tick_cnt + 1'b1 : tick_cnt;
    bit_cnt_nxt    = bit_cnt;
    sipo_shift_nxt = 1'b0;
    sipo_bit_nxt   = sipo_bit_q;
    rx_valid_nxt   = bus.rx_ack ? 1'b0 : rx_valid_q;
    ferr_nxt       = ferr_q;
    ovr_nxt        = bus.rx_ack ? 1'b0 : ovr_q;
`ifdef UART_RX_PARITY_EN
    parity_bit_nxt  = parity_bit_q;
    parity_pend_nxt = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rx_s) begin
          tick_cnt_nxt = '0;
          state_nxt    = START;
        end
      end
      START: begin
        if (tick_mid) begin
          if (!rx_s) begin
            tick_cnt_nxt = '0;
            bit_cnt_nxt  = '0;
            state_nxt    = DATA;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        if (tick_end) begin
          sipo_shift_nxt = 1'b1;
          sipo_bit_nxt   = rx_s;
          bit_cnt_nxt    = bit_cnt + 1'b1;
          if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick_end) begin
          parity_bit_nxt  = rx_s;
          parity_pend_nxt = 1'b1;
          state_nxt       = STOP;
        end
      end
`endif
      STOP: begin
        if (tick_end) begin
          ferr_nxt     = ~rx_s;
          rx_valid_nxt = 1'b1;
          // A simultaneous ack consumes the old frame, so only an unacked one overruns.
          ovr_nxt      = ovr_q | (rx_valid_q & ~bus.rx_ack);
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      sipo_shift_q <= 1'b0;
      sipo_bit_q   <= 1'b0;
      rx_valid_q   <= 1'b0;
      ferr_q       <= 1'b0;
      ovr_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state        <= state_nxt;
      tick_cnt     <= tick_cnt_nxt;
      bit_cnt      <= bit_cnt_nxt;
      sipo_shift_q <= sipo_shift_nxt;
      sipo_bit_q   <= sipo_bit_nxt;
      rx_valid_q   <= rx_valid_nxt;
      ferr_q       <= ferr_nxt;
      ovr_q        <= ovr_nxt;
      busy_q       <= busy_nxt;
    end
  end

`ifdef UART_RX_PARITY_EN
  // parity_load trails the capture by one clock so the checker sees a settled parity_bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_bit_q  <= 1'b0;
      parity_pend_q <= 1'b0;
      parity_load_q <= 1'b0;
    end else begin
      parity_bit_q  <= parity_bit_nxt;
      parity_pend_q <= parity_pend_nxt;
      parity_load_q <= parity_pend_q;
    end
  end

  assign bus.parity_bit  = parity_bit_q;
  assign bus.parity_load = parity_load_q;
`else
  assign bus.parity_bit  = 1'b0;
  assign bus.parity_load = 1'b0;
`endif

  assign bus.sipo_shift    = sipo_shift_q;
  assign bus.sipo_bit      = sipo_bit_q;
  assign bus.rx_valid      = rx_valid_q;
  assign bus.framing_error = ferr_q;
  assign bus.overrun       = ovr_q;
  assign bus.busy          = busy_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: table of frames plus glitch, overrun/ack and mid-frame reset sequences.
// Ticks arrive every 4 clocks; rx changes 3 clocks before each bit's first tick.
module tb_uart_rx_ctrl;
  localparam int OS = 16;
  localparam int NB = 8;
`ifdef UART_RX_PARITY_EN
  localparam int PEN = 1;
`else
  localparam int PEN = 0;
`endif
  // rx_valid rise, in clocks from the start-bit edge: stop sample tick index times 4 clocks/tick.
  localparam int LAT = 4 * (OS / 2 + OS * (NB + PEN + 1));

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_ctrl_if bus ();

  uart_rx_ctrl #(.OVERSAMPLE(OS), .DATA_BITS(NB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  int         shift_total = 0;
  int         pload_total = 0;
  int         valid_rise_cyc = 0;
  logic [7:0] shreg = 8'h00;
  logic       pbit_at_load = 1'b0;
  logic       valid_q = 1'b0;
  always @(negedge clk) begin
    if (bus.sipo_shift) begin
      shift_total++;
      shreg = {bus.sipo_bit, shreg[7:1]};
    end
    if (bus.parity_load) begin
      pload_total++;
      pbit_at_load = bus.parity_bit;
    end
    if (bus.rx_valid && !valid_q) valid_rise_cyc = cyc;
    valid_q = bus.rx_valid;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One tick period: three quiet clocks then one clock with sample_tick high.
  task automatic tick_period(input logic ack);
    bus.sample_tick = 1'b0;
    bus.rx_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.sample_tick = 1'b1;
    bus.rx_ack = ack;
    @(posedge clk); #1;
    bus.sample_tick = 1'b0;
    bus.rx_ack = 1'b0;
  endtask

  task automatic drive_bit(input logic b, input int nticks, input int ack_tick);
    bus.rx = b;
    for (int i = 1; i <= nticks; i++) tick_period(i == ack_tick);
  endtask

  // A low stop bit is held only through its sample point so the line is idle again afterwards.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input logic ack_at_stop);
    drive_bit(1'b0, OS, 0);
    for (int i = 0; i < NB; i++) drive_bit(d[i], OS, 0);
    if (PEN != 0) drive_bit(p, OS, 0);
    if (s) begin
      drive_bit(1'b1, OS, ack_at_stop ? OS / 2 : 0);
    end else begin
      drive_bit(1'b0, OS / 2, ack_at_stop ? OS / 2 : 0);
      drive_bit(1'b1, OS / 2, 0);
    end
  endtask

  task automatic ack_pulse();
    bus.rx_ack = 1'b1;
    @(posedge clk); #1;
    bus.rx_ack = 1'b0;
    @(posedge clk); #1;
  endtask

  function automatic logic [7:0] outs();
    return {bus.sipo_shift, bus.sipo_bit, bus.parity_bit, bus.parity_load,
            bus.rx_valid, bus.framing_error, bus.overrun, bus.busy};
  endfunction

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       s;
    logic       ack_before;
    logic       ack_at_stop;
    logic       exp_ferr;
    logic       exp_ovr;
  } vec_t;

  vec_t vecs[6];
  int   s0, l0, t0;

  initial begin
    vecs[0] = '{d: 8'hA5, p: 1'b0, s: 1'b1, ack_before: 1'b1, ack_at_stop: 1'b0, exp_ferr: 1'b0, exp_ovr: 1'b0};
    vecs[1] = '{d: 8'h3C, p: 1'b0, s: 1'b1, ack_before: 1'b1, ack_at_stop: 1'b0, exp_ferr: 1'b0, exp_ovr: 1'b0};
    vecs[2] = '{d: 8'hC3, p: 1'b1, s: 1'b1, ack_before: 1'b0, ack_at_stop: 1'b0, exp_ferr: 1'b0, exp_ovr: 1'b1};
    vecs[3] = '{d: 8'h01, p: 1'b1, s: 1'b0, ack_before: 1'b1, ack_at_stop: 1'b0, exp_ferr: 1'b1, exp_ovr: 1'b0};
    vecs[4] = '{d: 8'h80, p: 1'b0, s: 1'b1, ack_before: 1'b0, ack_at_stop: 1'b1, exp_ferr: 1'b0, exp_ovr: 1'b0};
    vecs[5] = '{d: 8'h55, p: 1'b1, s: 1'b1, ack_before: 1'b0, ack_at_stop: 1'b0, exp_ferr: 1'b0, exp_ovr: 1'b1};

    bus.rx = 1'b1;
    bus.sample_tick = 1'b0;
    bus.rx_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", outs(), 8'h00);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Five-tick low glitch on an idle line must be rejected at the mid-bit sample.
    s0 = shift_total;
    drive_bit(1'b0, 3, 0);
    check("glitch_busy_high", bus.busy, 1);
    drive_bit(1'b0, 2, 0);
    drive_bit(1'b1, OS, 0);
    check("glitch_no_shift", shift_total - s0, 0);
    check("glitch_busy_low", bus.busy, 0);
    check("glitch_no_valid", bus.rx_valid, 0);

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].ack_before) begin
        ack_pulse();
        check($sformatf("v%0d_ack_clr_valid", v), bus.rx_valid, 0);
        check($sformatf("v%0d_ack_clr_ovr", v), bus.overrun, 0);
      end
      s0 = shift_total;
      l0 = pload_total;
      t0 = cyc;
      send_frame(vecs[v].d, vecs[v].p, vecs[v].s, vecs[v].ack_at_stop);
      check($sformatf("v%0d_shift_count", v), shift_total - s0, NB);
      check($sformatf("v%0d_data", v), shreg, vecs[v].d);
      check($sformatf("v%0d_parity_loads", v), pload_total - l0, PEN);
      check($sformatf("v%0d_parity_bit", v), bus.parity_bit, (PEN != 0) ? vecs[v].p : 1'b0);
`ifdef UART_RX_PARITY_EN
      check($sformatf("v%0d_parity_at_load", v), pbit_at_load, vecs[v].p);
`endif
      check($sformatf("v%0d_rx_valid", v), bus.rx_valid, 1);
      check($sformatf("v%0d_framing_error", v), bus.framing_error, vecs[v].exp_ferr);
      check($sformatf("v%0d_overrun", v), bus.overrun, vecs[v].exp_ovr);
      check($sformatf("v%0d_busy_idle", v), bus.busy, 0);
      if (vecs[v].ack_before)
        check($sformatf("v%0d_valid_latency", v), valid_rise_cyc - t0, LAT);
    end

    ack_pulse();
    check("final_ack_valid", bus.rx_valid, 0);
    check("final_ack_overrun", bus.overrun, 0);

    // Reset in the middle of 0xFF, after its third data bit has been shifted.
    s0 = shift_total;
    drive_bit(1'b0, OS, 0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1, OS, 0);
    drive_bit(1'b1, 4, 0);
    check("abort_shifts_before_reset", shift_total - s0, 3);
    check("abort_busy_before_reset", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_outputs_cleared", outs(), 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    s0 = shift_total;
    l0 = pload_total;
    t0 = cyc;
    send_frame(8'h55, 1'b0, 1'b1, 1'b0);
    check("post_reset_shifts", shift_total - s0, NB);
    check("post_reset_data", shreg, 8'h55);
    check("post_reset_parity_loads", pload_total - l0, PEN);
    check("post_reset_valid", bus.rx_valid, 1);
    check("post_reset_ferr", bus.framing_error, 0);
    check("post_reset_overrun", bus.overrun, 0);
    check("post_reset_latency", valid_rise_cyc - t0, LAT);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
